// File: rtl/sync_fifo_peek.sv
// ---------------------------------------------------------------------------
// sync_fifo_peek
//
// Synchronous FIFO for game-state queues, for example snake body segment
// coordinates. The producer writes the head and the consumer reads the tail.
// The FIFO provides:
//   - a show-ahead output of the oldest entry
//   - an occupancy count
//   - full, empty, almost-full and almost-empty flags
//   - one-cycle overflow and underflow pulses for rejected requests
//   - an optional random-access peek port, used for collision scans over the
//     stored entries
//
// Optional feature macro: FIFO_PEEK_EN
//   Defined   : the peek port reads mem[(rd_ptr + peek_idx) mod DEPTH].
//   Undefined : the peek adder and the second read port are not built.
//               peek_data and peek_valid are tied to 0.
//
// Parameters:
//   DATA_WIDTH : width of each entry in bits (>= 1)
//   DEPTH      : number of entries (power of two, >= 2)
//   AF_LEVEL   : almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL   : almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk          in   clock; all state changes on the rising edge
//   rstn         in   synchronous active-low reset
//   write        in   push request
//   read         in   pop request
//   i_data       in   push data
//   o_data       out  oldest entry (show-ahead, combinational)
//   peek_idx     in   offset from the oldest entry (0 = oldest)
//   peek_data    out  entry at oldest + peek_idx
//   peek_valid   out  peek_idx < count
//   count        out  current occupancy, 0..DEPTH
//   is_empty     out  count == 0
//   is_full      out  count == DEPTH
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   overflow     out  one-cycle pulse: write rejected on the previous edge
//   underflow    out  one-cycle pulse: read rejected on the previous edge
// ---------------------------------------------------------------------------
module sync_fifo_peek #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      write,
  input  logic                      read,
  input  logic [DATA_WIDTH-1:0]     i_data,
  output logic [DATA_WIDTH-1:0]     o_data,
  input  logic [$clog2(DEPTH)-1:0]  peek_idx,
  output logic [DATA_WIDTH-1:0]     peek_data,
  output logic                      peek_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      is_empty,
  output logic                      is_full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  wr_ok;
  logic                  rd_ok;

  // Full and empty come from the occupancy count, not from pointer equality.
  // That keeps the pointers at exactly AW bits, and they wrap naturally.
  assign is_empty     = (count_q == '0);
  assign is_full      = (count_q == FULL_COUNT);
  // The signed int comparison keeps a threshold of 0 legal without building
  // a constant unsigned comparison.
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign count        = count_q;

  // A write into a full FIFO is still accepted when a read happens in the
  // same cycle, because the read frees the slot.
  // A read from an empty FIFO is always rejected, because there is no
  // write-to-read bypass.
  assign wr_ok = write & (~is_full | read);
  assign rd_ok = read & ~is_empty;

  // Storage has no reset. Stale words are never observable as valid data.
  always_ff @(posedge clk) begin
    if (rstn && wr_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointer, count and error-pulse state.
  // Requests seen during reset are ignored.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count_q <= count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_q <= count_q - 1'b1;
      end
      overflow  <= write & ~wr_ok;
      underflow <= read & ~rd_ok;
    end
  end

  // Show-ahead output: the oldest entry, read combinationally.
  assign o_data = mem[rd_ptr];

`ifdef FIFO_PEEK_EN
  // Random-access peek port for collision scans.
  // The address wraps modulo DEPTH through AW-bit arithmetic.
  logic [AW-1:0] peek_addr;

  assign peek_addr  = rd_ptr + peek_idx;
  assign peek_data  = mem[peek_addr];
  assign peek_valid = ({1'b0, peek_idx} < count_q);
`else
  // The peek port is not built. The outputs are tied off and the index is
  // intentionally left unconsumed.
  logic unused_peek_idx;

  assign unused_peek_idx = ^peek_idx;
  assign peek_data       = '0;
  assign peek_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_peek.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_peek
//
// Self-checking bench for sync_fifo_peek.
// Configuration: DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
//
// The reference model is a queue of entries plus the accept rules. Every
// visible output is compared against that model after each clock edge.
// Directed sequences come first, followed by a randomized run with
// occasional resets.
// Peek expectations follow FIFO_PEEK_EN when this file is compiled.
// ---------------------------------------------------------------------------
module tb_sync_fifo_peek;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;

  logic          clk;
  logic          rstn;
  logic          write;
  logic          read;
  logic [DW-1:0] i_data;
  logic [DW-1:0] o_data;
  logic [1:0]    peek_idx;
  logic [DW-1:0] peek_data;
  logic          peek_valid;
  logic [2:0]    count;
  logic          is_empty;
  logic          is_full;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] model_q[$];
  logic          exp_ov = 1'b0;
  logic          exp_un = 1'b0;

  sync_fifo_peek #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AF_LEVEL(AFL),
    .AE_LEVEL(AEL)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .write(write),
    .read(read),
    .i_data(i_data),
    .o_data(o_data),
    .peek_idx(peek_idx),
    .peek_data(peek_data),
    .peek_valid(peek_valid),
    .count(count),
    .is_empty(is_empty),
    .is_full(is_full),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  // A mismatch prints a FAIL line and is counted.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=0x%0h expected=0x%0h", tag, $time,
               got, exp);
    end
  endtask

  // Check every output against the model after a clock edge.
  task automatic checkAll();
    int n;
    n = model_q.size();
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("is_empty", 32'(is_empty), 32'(n == 0));
    checkOutput("is_full", 32'(is_full), 32'(n == DEPTH));
    checkOutput("almost_full", 32'(almost_full), 32'(n >= AFL));
    checkOutput("almost_empty", 32'(almost_empty), 32'(n <= AEL));
    checkOutput("overflow", 32'(overflow), 32'(exp_ov));
    checkOutput("underflow", 32'(underflow), 32'(exp_un));
    if (n > 0) begin
      checkOutput("o_data", 32'(o_data), 32'(model_q[0]));
    end
`ifdef FIFO_PEEK_EN
    checkOutput("peek_valid", 32'(peek_valid), 32'(int'(peek_idx) < n));
    if (int'(peek_idx) < n) begin
      checkOutput("peek_data", 32'(peek_data), 32'(model_q[int'(peek_idx)]));
    end
`else
    checkOutput("peek_valid_off", 32'(peek_valid), 32'd0);
    checkOutput("peek_data_off", 32'(peek_data), 32'd0);
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the clock edge, and
  // check the outputs shortly after the edge.
  task automatic applyStimulus(input logic rn, input logic w, input logic r,
                               input logic [DW-1:0] d, input logic [1:0] pi);
    bit full_m;
    bit wr_ok_m;
    bit rd_ok_m;
    @(negedge clk);
    rstn     = rn;
    write    = w;
    read     = r;
    i_data   = d;
    peek_idx = pi;
    @(posedge clk);
    if (!rn) begin
      model_q.delete();
      exp_ov = 1'b0;
      exp_un = 1'b0;
    end else begin
      full_m  = (model_q.size() == DEPTH);
      wr_ok_m = w && (!full_m || r);
      rd_ok_m = r && (model_q.size() > 0);
      if (rd_ok_m) begin
        void'(model_q.pop_front());
      end
      if (wr_ok_m) begin
        model_q.push_back(d);
      end
      exp_ov = w && !wr_ok_m;
      exp_un = r && !rd_ok_m;
    end
    #1;
    checkAll();
  endtask

  initial begin
    rstn     = 1'b0;
    write    = 1'b0;
    read     = 1'b0;
    i_data   = '0;
    peek_idx = '0;

    // Hold reset for two cycles with write asserted; the write is ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);

    // Fill with 1..5. The fifth write overflows.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'(i), 2'(i));
    end
    // The overflow pulse drops after one idle cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2'd3);
    // Drain in order. The extra read underflows.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 2'd0);
    end

    // Read alone on empty, then read and write together on empty.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h00AA, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 2'd0);

    // Fill with 0x10..0x13, then read and write together while full.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'(16 + i), 2'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0014, 2'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);

    // Reset, push/pop to wrap the pointers, then load 0x20..0x22 and peek.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 2'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'(16'h0100 + i), 2'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 2'd0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'(16'h0020 + i), 2'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2'd3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 99) < 55),
                    ($urandom_range(0, 99) < 45),
                    16'($urandom),
                    2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_peek.md
Name: sync_fifo_peek

Overview:
Parametrised synchronous FIFO for game-state queues, such as snake body segment coordinates, head at write side and tail at read side. It is the successor to the basic pointer FIFO. It adds full/almost flags, an occupancy count, overflow/underflow protection with error pulses, and a random-access peek port for collision scans over stored entries. It sits between game logic (producer/consumer) and the renderer/collision checker.

Parameters:
- DATA_WIDTH, 16, width of each entry in bits (≥1).
- DEPTH, 64, number of entries; must be a power of two, ≥2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- write  in  1  push request.
- read  in  1  pop request.
- i_data  in  DATA_WIDTH  push data.
- o_data  out  DATA_WIDTH  oldest entry (show-ahead).
- peek_idx  in  $clog2(DEPTH)  offset from oldest entry (0 = oldest).
- peek_data  out  DATA_WIDTH  entry at oldest+peek_idx.
- peek_valid  out  1  peek_idx < count.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- is_empty  out  1  count == 0.
- is_full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset: synchronous. While rstn=0 at a clock edge, the write/read pointers and count are cleared to 0, and overflow/underflow are cleared to 0.
  - Immediately after reset: is_empty=1, is_full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0), peek_valid=0.
  - Memory contents are not cleared. o_data and peek_data are don't-care while empty / !peek_valid.
  - Reset mid-operation discards all contents. write/read asserted in the same cycle as rstn=0 are ignored.
- Pointers: $clog2(DEPTH) bits, wrap naturally DEPTH-1 → 0. Full/empty are derived from count, not pointer equality.
- Accept rules, evaluated each cycle:
  - wr_ok = write & (!is_full | read).
  - rd_ok = read & !is_empty.
- Full + write + read: both accepted. count unchanged, no overflow.
- Empty + write + read: write accepted, read rejected. count becomes 1, underflow pulses.
- Write with !wr_ok: data dropped, memory/pointer untouched, overflow=1 next cycle.
- Read with !rd_ok: pointer untouched, underflow=1 next cycle.
- Accepted write: mem[wr_ptr] ← i_data, wr_ptr+1.
- Accepted read: rd_ptr+1.
- count updates:
  - +1 if wr_ok & !rd_ok.
  - −1 if rd_ok & !wr_ok.
  - otherwise unchanged.
- Flags and count are registered or derived from the registered count. They are valid the cycle after the causing edge.
- o_data = mem[rd_ptr], combinational read.
  - A written word is visible on o_data the cycle after its write edge.
  - No write-to-read bypass in the same cycle.
- peek_data = mem[(rd_ptr+peek_idx) mod DEPTH], combinational. The address wraps modulo DEPTH.
- peek_valid = (peek_idx < count).
- Overflow/underflow are single-cycle pulses, not sticky. Back-to-back rejected requests hold them high continuously.

Optional Feature:
- Macro: FIFO_PEEK_EN.
- Defined: peek port behaves as above.
- Undefined: the peek address adder and second read port are not built. Ports remain present; peek_data is driven 0 and peek_valid is driven 0. All other behaviour is identical.

Test Plan:
- Reset/initial state: hold rstn=0 for 2 cycles while write=1 → count=0, is_empty=1, is_full=0, almost_empty=1, no pointer movement after release.
- Fill/overflow (DEPTH=4, AF_LEVEL=3): write 0x0001..0x0005 on consecutive cycles, read=0.
  - count reaches 4, is_full=1, almost_full=1 from count=3.
  - Fifth write gives overflow pulse one cycle.
  - Drain returns 0x0001..0x0004 in order.
- Underflow and simultaneous ops on empty:
  - read=1 alone on empty → underflow pulse, count=0.
  - write=1, read=1, i_data=0x00AA on empty → count=1, o_data=0x00AA, underflow pulse.
- Full read+write: fill DEPTH=4 with 0x10..0x13, then write=1 read=1 i_data=0x14 → count stays 4, no overflow, o_data=0x11.
- Wrap-around and peek (FIFO_PEEK_EN): 10 cycles of push/pop to move pointers past DEPTH-1, then load 0x20,0x21,0x22.
  - peek_idx=2 → peek_data=0x22, peek_valid=1.
  - peek_idx=3 → peek_valid=0.
- Peek disabled: same stimulus without FIFO_PEEK_EN → peek_data=0, peek_valid=0, FIFO data path unchanged.
